// File: rtl/sp_ram_model.sv
// Behavioural single-port synchronous RAM with a power-up clear sequencer,
// selectable write mode, 1- or 2-cycle read latency and a read-valid strobe.
module sp_ram_model #(
    parameter int unsigned       ADDR_W     = 5,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       RD_LAT     = 1,
    parameter int unsigned       WRITE_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              ram_en,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wr_data,
    output logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_rd_valid,
    output logic              init_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_clr_ptr;
    logic [ADDR_W:0]   w_clr_next;
    logic              r_init_busy;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data1;
    logic              r_rd_valid1;
    logic              w_acc;

    assign w_acc      = (r_state == READY) && ram_en;
    assign w_clr_next = r_clr_ptr + {{ADDR_W{1'b0}}, 1'b1};
    assign init_busy  = r_init_busy;

    // The extra pointer bit sets exactly when the last location has been written.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= CLEAR;
            r_clr_ptr   <= '0;
            r_init_busy <= 1'b1;
        end else if (r_state == CLEAR) begin
            r_clr_ptr <= w_clr_next;
            if (w_clr_next[ADDR_W]) begin
                r_state     <= READY;
                r_init_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_ptr[ADDR_W-1:0]] <= INIT_VAL;
            end else if (w_acc && ram_we) begin
                r_mem[ram_addr] <= ram_wr_data;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rd_data1  <= '0;
            r_rd_valid1 <= 1'b0;
        end else begin
            r_rd_valid1 <= w_acc && !ram_we;
            if (w_acc) begin
                if (!ram_we || WRITE_MODE == 0) begin
                    r_rd_data1 <= r_mem[ram_addr];
                end else if (WRITE_MODE == 1) begin
                    r_rd_data1 <= ram_wr_data;
                end
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_rd_data2;
            logic              r_rd_valid2;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    r_rd_data2  <= '0;
                    r_rd_valid2 <= 1'b0;
                end else begin
                    r_rd_data2  <= r_rd_data1;
                    r_rd_valid2 <= r_rd_valid1;
                end
            end

            assign ram_rd_data  = r_rd_data2;
            assign ram_rd_valid = r_rd_valid2;
        end else begin : g_lat1
            assign ram_rd_data  = r_rd_data1;
            assign ram_rd_valid = r_rd_valid1;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_model.sv
// Directed bench for sp_ram_model: four instances (read-first, write-first,
// no-change, latency 2) share stimulus; a scoreboard queue holds expected outputs.
module tb_sp_ram_model;

    logic       clk;
    logic       rst;
    logic       en;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wd;

    logic [7:0] d_rf, d_wf, d_nc, d_l2;
    logic       v_rf, v_wf, v_nc, v_l2;
    logic       b_rf, b_wf, b_nc, b_l2;

    sp_ram_model #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1), .WRITE_MODE(0), .INIT_VAL(8'hA5)) u_rf (
        .sys_clk(clk), .sys_rst(rst), .ram_en(en), .ram_we(we), .ram_addr(addr),
        .ram_wr_data(wd), .ram_rd_data(d_rf), .ram_rd_valid(v_rf), .init_busy(b_rf));
    sp_ram_model #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1), .WRITE_MODE(1), .INIT_VAL(8'hA5)) u_wf (
        .sys_clk(clk), .sys_rst(rst), .ram_en(en), .ram_we(we), .ram_addr(addr),
        .ram_wr_data(wd), .ram_rd_data(d_wf), .ram_rd_valid(v_wf), .init_busy(b_wf));
    sp_ram_model #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1), .WRITE_MODE(2), .INIT_VAL(8'hA5)) u_nc (
        .sys_clk(clk), .sys_rst(rst), .ram_en(en), .ram_we(we), .ram_addr(addr),
        .ram_wr_data(wd), .ram_rd_data(d_nc), .ram_rd_valid(v_nc), .init_busy(b_nc));
    sp_ram_model #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2), .WRITE_MODE(0), .INIT_VAL(8'hA5)) u_l2 (
        .sys_clk(clk), .sys_rst(rst), .ram_en(en), .ram_we(we), .ram_addr(addr),
        .ram_wr_data(wd), .ram_rd_data(d_l2), .ram_rd_valid(v_l2), .init_busy(b_l2));

    typedef struct packed {
        logic            busy;
        logic [3:0][7:0] d;
        logic [3:0]      v;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_mem [32];
    bit         m_ready;
    int         m_clr;
    logic [7:0] md0, md1, md2, l2d;
    logic       mv, l2v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_clr   = 0;
        md0 = 8'h00; md1 = 8'h00; md2 = 8'h00; mv = 1'b0;
        l2d = 8'h00; l2v = 1'b0;
    endtask

    // One clock edge: model the edge with the held inputs, queue the result.
    task automatic cycle();
        exp_t       e;
        logic [7:0] old;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            l2d = md0;
            l2v = mv;
            if (!m_ready) begin
                m_mem[m_clr] = 8'hA5;
                m_clr++;
                mv = 1'b0;
                if (m_clr == 32) m_ready = 1'b1;
            end else if (en) begin
                old = m_mem[addr];
                if (!we) begin
                    md0 = old; md1 = old; md2 = old;
                    mv  = 1'b1;
                end else begin
                    m_mem[addr] = wd;
                    md0 = old;
                    md1 = wd;
                    mv  = 1'b0;
                end
            end else begin
                mv = 1'b0;
            end
        end
        e.busy = !m_ready;
        e.d[0] = md0; e.d[1] = md1; e.d[2] = md2; e.d[3] = l2d;
        e.v[0] = mv;  e.v[1] = mv;  e.v[2] = mv;  e.v[3] = l2v;
        q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("rf_data",  d_rf, e.d[0]);
            check("wf_data",  d_wf, e.d[1]);
            check("nc_data",  d_nc, e.d[2]);
            check("l2_data",  d_l2, e.d[3]);
            check("rf_valid", 8'(v_rf), 8'(e.v[0]));
            check("wf_valid", 8'(v_wf), 8'(e.v[1]));
            check("nc_valid", 8'(v_nc), 8'(e.v[2]));
            check("l2_valid", 8'(v_l2), 8'(e.v[3]));
            check("rf_busy",  8'(b_rf), 8'(e.busy));
            check("l2_busy",  8'(b_l2), 8'(e.busy));
            check("wf_busy",  8'(b_wf), 8'(e.busy));
            check("nc_busy",  8'(b_nc), 8'(e.busy));
        end
    end

    task automatic drive(input logic e_i, input logic w_i, input logic [4:0] a_i, input logic [7:0] d_i);
        en = e_i; we = w_i; addr = a_i; wd = d_i;
        cycle();
    endtask

    // Assert reset between edges and check outputs return without a clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        model_reset();
        check("async_rf_data",  d_rf, 8'h00);
        check("async_l2_data",  d_l2, 8'h00);
        check("async_rf_valid", 8'(v_rf), 8'h00);
        check("async_l2_valid", 8'(v_l2), 8'h00);
        check("async_rf_busy",  8'(b_rf), 8'h01);
        check("async_l2_busy",  8'(b_l2), 8'h01);
        cycle();
        rst = 1'b0;
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        en = 1'b1; we = 1'b0;
        while (b_rf && n < 40) begin
            addr = 5'(n);
            cycle();
            n++;
        end
        check(tag, 8'(n), 8'd32);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wd = '0;
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;

        // Clear sequence length, requests ignored meanwhile
        count_clear("clear_cycles");

        // Cleared contents, back-to-back reads
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 5'(i), 8'h00);

        // Fill with addr+0x10, then back-to-back readback
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, 5'(i), 8'(i + 16));
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 5'(i), 8'h00);
        drive(1'b0, 1'b0, 5'd0, 8'h00);

        // Latency comparison at addrs 1,2,3
        drive(1'b1, 1'b0, 5'd1, 8'h00);
        check("lat_rf_first", d_rf, 8'h11);
        check("lat_l2_notyet", 8'(v_l2), 8'h00);
        drive(1'b1, 1'b0, 5'd2, 8'h00);
        check("lat_l2_first", d_l2, 8'h11);
        drive(1'b1, 1'b0, 5'd3, 8'h00);
        drive(1'b0, 1'b0, 5'd0, 8'h00);
        check("lat_l2_last", d_l2, 8'h13);
        drive(1'b0, 1'b0, 5'd0, 8'h00);

        // Write modes at addr 3 with a known prior output value
        drive(1'b1, 1'b1, 5'd3, 8'h11);
        drive(1'b1, 1'b0, 5'd5, 8'h00);
        drive(1'b1, 1'b1, 5'd3, 8'h22);
        check("wm_read_first", d_rf, 8'h11);
        check("wm_write_first", d_wf, 8'h22);
        check("wm_no_change", d_nc, 8'h15);
        drive(1'b0, 1'b0, 5'd0, 8'h00);

        // Read-after-write on the next edge
        drive(1'b1, 1'b1, 5'd7, 8'h5A);
        drive(1'b1, 1'b0, 5'd7, 8'h00);
        check("raw_data", d_rf, 8'h5A);

        // Enable gating: writes attempted with ram_en low
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 5'($urandom_range(31)), 8'($urandom));
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 5'(i), 8'h00);
        drive(1'b0, 1'b0, 5'd0, 8'h00);

        // Reset with a read in flight
        drive(1'b1, 1'b0, 5'd9, 8'h00);
        async_reset();
        count_clear("clear_after_op_reset");

        // Reset at clear pointer 17
        async_reset();
        en = 1'b0;
        repeat (17) cycle();
        async_reset();
        count_clear("clear_after_mid_reset");
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 5'(i + 12), 8'h00);
        drive(1'b0, 1'b0, 5'd0, 8'h00);
        drive(1'b0, 1'b0, 5'd0, 8'h00);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_ram_model.md
# sp_ram_model

Behavioural single-port synchronous RAM that answers the `ram_en`/`ram_we`/`ram_addr`/`ram_wr_data`/`ram_rd_data` interface driven by our RAM read/write initiator. It is a drop-in, vendor-independent replacement for the generated block-memory IP in simulation and in portable builds. After reset it clears the array with a built-in sequencer. It has configurable read latency, a configurable write mode and a read-data valid strobe.

## Interface
- `ADDR_W`, 5: address width; depth = 2^ADDR_W.
- `DATA_W`, 8: data width.
- `RD_LAT`, 1: read latency in cycles; legal values are 1 (array output register only) or 2 (extra output register).
- `WRITE_MODE`, 0: 0 = read-first, 1 = write-first, 2 = no-change.
- `INIT_VAL`, 0: value written to every location by the clear sequencer.

Ports:
- `sys_clk`  in  1: the single clock; all logic is on the rising edge.
- `sys_rst`  in  1: reset, asynchronous and active-high.
- `ram_en`  in  1: port enable; no access when low.
- `ram_we`  in  1: write enable; only meaningful when `ram_en`=1.
- `ram_addr`  in  ADDR_W: access address.
- `ram_wr_data`  in  DATA_W: write data.
- `ram_rd_data`  out  DATA_W: read data.
- `ram_rd_valid`  out  1: one-cycle strobe marking `ram_rd_data` as the result of an accepted read.
- `init_busy`  out  1: clear sequencer active; requests are ignored while high.

## Operation
- State machine has two states: CLEAR and READY.
- Reset behaviour:
  - Asserting `sys_rst` forces state CLEAR and clear pointer 0.
  - Reset values: `init_busy`=1, `ram_rd_data`=0, `ram_rd_valid`=0, and all pipeline registers 0.
  - The array itself is not reset.
- CLEAR state:
  - Each cycle with reset low writes INIT_VAL at the clear pointer, then increments the pointer.
  - After writing address 2^ADDR_W−1, the state goes to READY and `init_busy` drops.
  - CLEAR lasts exactly 2^ADDR_W cycles.
  - `ram_en`/`ram_we` are ignored; no `ram_rd_valid` is produced and `ram_rd_data` stays 0.
- READY state, a request is accepted on any edge with `ram_en`=1:
  - Read (`ram_we`=0): the output stage loads mem[addr] and a valid token enters the latency pipeline.
  - Write (`ram_we`=1): mem[addr] ← `ram_wr_data`. The output stage then depends on WRITE_MODE:
    - read-first: loads the old contents.
    - write-first: loads the new data.
    - no-change: holds.
  - A write never produces `ram_rd_valid`.
  - `ram_en`=0: the array and output stage hold, and no token is generated.
- With RD_LAT=2, the second register always advances; it is not gated by `ram_en`. Its valid bit follows the first stage one cycle later.
- Address arithmetic: the clear pointer is ADDR_W+1 bits wide so termination is detected without wrap aliasing. Request addresses are used as-is; all values are in range.
- Reset mid-operation, including mid-CLEAR: tokens in flight are dropped, outputs return to reset values, and CLEAR restarts from address 0.

## Timing
- A read sampled at edge k gives `ram_rd_data` = mem[addr] and `ram_rd_valid`=1 after edge k+RD_LAT−1, i.e. visible in the cycle following edge k for RD_LAT=1.
- Full throughput: one access per cycle. Back-to-back reads give back-to-back valid strobes in request order.
- Read-after-write to the same address on the next edge returns the new data.
- `ram_rd_valid` is high for exactly one cycle per accepted read.
- `init_busy` falls after the 2^ADDR_W-th edge following reset release. A request sampled on that same edge is ignored; the first accepted request is on the next edge.
- Between reads, `ram_rd_data` holds its last value, except that writes update it in read-first and write-first modes.

## Test plan
- Clear check (ADDR_W=5, INIT_VAL=8'hA5): release reset, count edges until `init_busy` falls (must be 32), then read all 32 addresses → every read returns 8'hA5 with one `ram_rd_valid` each.
- Write/read (RD_LAT=1): write 0x00..0x1F with data addr+8'h10, then read back-to-back → data 0x10..0x2F on consecutive cycles, and `ram_rd_valid` continuous for 32 cycles.
- Write modes: mem[3]=8'h11, then write 8'h22 to addr 3 → `ram_rd_data` shows 8'h11 in read-first, 8'h22 in write-first, and the prior value in no-change; `ram_rd_valid`=0 in all three.
- Latency 2: RD_LAT=2, reads at addrs 1,2,3 on consecutive edges → data and valid appear one cycle later than with RD_LAT=1, in order, without gaps.
- Enable gating: `ram_en`=0 with `ram_we`=1 and varying address/data for 10 cycles → memory unchanged on readback, `ram_rd_data` stable, no valid strobes.
- Reset mid-CLEAR: assert `sys_rst` at clear pointer 17, then release → outputs return to 0/0/1 asynchronously, and `init_busy` stays high for a full 32 cycles from the release.
